// File: rtl/alu_result_framer_if.sv
// Result-in / byte-out stream bundle for the ALU result framer.
interface alu_result_framer_if;
  logic [15:0] res_in;
  logic        res_valid;
  logic [1:0]  res_tag;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  // master: result producer and byte consumer; slave: the framer
  modport master (
    output res_in, res_valid, res_tag, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  res_in, res_valid, res_tag, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/alu_result_framer.sv
// Buffers tagged ALU results in a FIFO and serialises each as a 4-byte frame:
// header, MSB, LSB, XOR checksum.
module alu_result_framer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_framer_if.slave     bus,
  input  logic                   clr_ovf,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] res;
  } entry_t;

  typedef enum logic [2:0] {IDLE, HDR, MSB, LSB, CHK} state_t;

  state_t        state;
  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        hold;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          advance;
  logic          pop;
  logic          push;
  logic          drop;
  logic          active_nxt;

  function automatic logic [7:0] header(input logic [1:0] tag);
    return {4'b1010, 2'b00, tag};
  endfunction

  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // Pop at IDLE or on the CHK handshake so frames run back to back
  always_comb begin
    advance    = bus.out_valid && bus.out_ready;
    pop        = (count != '0) && ((state == IDLE) || ((state == CHK) && advance));
    push       = bus.res_valid && ((count != CW'(DEPTH)) || pop);
    drop       = bus.res_valid && !push;
    count_nxt  = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
    active_nxt = !(((state == IDLE) || ((state == CHK) && advance)) && !pop);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry_t'{tag: bus.res_tag, res: bus.res_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      hold          <= '0;
      ovf           <= 1'b0;
      busy          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= head;
      end
      count <= count_nxt;
      busy  <= active_nxt || (count_nxt != '0);
      // Sticky drop flag; a drop in the same cycle beats the clear
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            state         <= HDR;
            bus.out_valid <= 1'b1;
            bus.out_data  <= header(head.tag);
          end
        end
        HDR: begin
          if (advance) begin
            state        <= MSB;
            bus.out_data <= hold.res[15:8];
          end
        end
        MSB: begin
          if (advance) begin
            state        <= LSB;
            bus.out_data <= hold.res[7:0];
          end
        end
        LSB: begin
          if (advance) begin
            state        <= CHK;
            bus.out_data <= header(hold.tag) ^ hold.res[15:8] ^ hold.res[7:0];
          end
        end
        CHK: begin
          if (advance) begin
            if (pop) begin
              state        <= HDR;
              bus.out_data <= header(head.tag);
            end else begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_data  <= '0;
        end
      endcase
    end
  end

endmodule
